// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants and types.
// Used by the VDU fetch engine and other SRAM clients.
package mem_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 32;

    // Matches the controller's diagnostic "granted" encoding.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        VDU  = 2'd1,
        DE   = 2'd2,
        IQ   = 2'd3
    } client_e;

    localparam int VDU_H_PIXELS     = 640;
    localparam int VDU_V_LINES      = 480;
    localparam int VDU_PIX_PER_WORD = 4;
    localparam int VDU_FRAME_WORDS  =
        VDU_H_PIXELS * VDU_V_LINES / VDU_PIX_PER_WORD;

    typedef enum logic {
        VF_IDLE  = 1'b0,
        VF_FETCH = 1'b1
    } vf_state_e;

endpackage

// File: rtl/vdu_fetch_if.sv
// VDU read-port and word-stream bundle.
// master: fetch engine (vdu_req/address out, word out); slave: peers.
interface vdu_fetch_if
    import mem_pkg::*;
#(
    parameter int AW = SRAM_AW
);

    logic               vdu_req;
    logic               vdu_ack;
    logic [AW-1:0]      vdu_address;
    logic [SRAM_DW-1:0] vdu_data;
    logic               word_valid;
    logic               word_ready;
    logic [SRAM_DW-1:0] word_data;

    modport master (
        output vdu_req,
        output vdu_address,
        input  vdu_ack,
        input  vdu_data,
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  vdu_req,
        input  vdu_address,
        output vdu_ack,
        output vdu_data,
        input  word_valid,
        input  word_data,
        output word_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head word is read straight from storage.
// Ports: push/wdata, pop/rdata, flush, count, empty, full.
module sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vdu_fetch.sv
// Frame prefetch engine: streams frame words from SRAM into a FIFO.
// Ports: frame_start/base_addr, bus (mem + word stream), frame_done, underrun.
module vdu_fetch
    import mem_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FRAME_WORDS = VDU_FRAME_WORDS,
    parameter int AW          = SRAM_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic [AW-1:0] base_addr,
    vdu_fetch_if.master   bus,
    output logic          frame_done,
    output logic          underrun
);

    localparam int IW = $clog2(FRAME_WORDS + 1);
    localparam int CW = $clog2(DEPTH + 1);

    vf_state_e    state;
    vf_state_e    state_nx;
    logic [AW-1:0] addr;
    logic [IW-1:0] issued;
    logic          inflight;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          req;
    logic          ack_ok;
    logic          push;
    logic          all_issued;

    assign all_issued = (issued == IW'(FRAME_WORDS));
    // The word still in flight already owns a FIFO slot.
    assign req = (state == VF_FETCH) && !all_issued &&
                 ((int'(count) + int'(inflight)) < DEPTH);
    assign ack_ok = bus.vdu_ack && req && !frame_start;
    // Data for a pre-flush request is dropped on frame_start.
    assign push = inflight && !frame_start;

    assign bus.vdu_req     = req;
    assign bus.vdu_address = addr;
    assign bus.word_valid  = !empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SRAM_DW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (bus.vdu_data),
        .pop   (bus.word_ready),
        .flush (frame_start),
        .rdata (bus.word_data),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_nx = state;
        if (frame_start) begin
            state_nx = VF_FETCH;
        end else if (state == VF_FETCH && all_issued) begin
            state_nx = VF_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= VF_IDLE;
            addr       <= '0;
            issued     <= '0;
            inflight   <= 1'b0;
            frame_done <= 1'b1;
            underrun   <= 1'b0;
        end else begin
            state <= state_nx;
            if (frame_start) begin
                addr       <= base_addr;
                issued     <= '0;
                inflight   <= 1'b0;
                frame_done <= 1'b0;
                underrun   <= 1'b0;
            end else begin
                if (ack_ok) begin
                    addr     <= addr + AW'(1);
                    issued   <= issued + IW'(1);
                    inflight <= 1'b1;
                end else begin
                    inflight <= 1'b0;
                end
                // At most one word is outstanding, so issued counts it.
                if (push && all_issued) begin
                    frame_done <= 1'b1;
                end
                if (bus.word_ready && empty &&
                    (state == VF_FETCH || !frame_done)) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    a_ack_needs_req: assert property (
        @(posedge clk) disable iff (reset)
        bus.vdu_ack |-> req
    ) else $error("vdu_ack without vdu_req");

    a_no_push_full: assert property (
        @(posedge clk) disable iff (reset)
        !(push && full && !bus.word_ready)
    ) else $error("FIFO push while full");

endmodule

// File: tb/tb_vdu_fetch.sv
// Self-checking bench for vdu_fetch with a memory controller model
// and a queue-based reference of the expected word stream.
`timescale 1ns/100ps
module tb_vdu_fetch;
    import mem_pkg::*;

    localparam int DEPTH = 8;
    localparam int FW    = 16;
    localparam int AW    = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          frame_done;
    logic          underrun;

    vdu_fetch_if #(.AW(AW)) bus ();

    vdu_fetch #(
        .DEPTH       (DEPTH),
        .FRAME_WORDS (FW),
        .AW          (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .base_addr   (base_addr),
        .bus         (bus.master),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    int pops = 0;
    int rmode = 0;
    logic hold = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW-1:0] ack_addr = '0;
    logic [AW-1:0] first_addr = '0;
    logic [31:0] seed = 32'h0;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return ({14'h0, a} * 32'h9E37_79B1) ^ seed;
    endfunction

    // Controller model (posedge+1) and serialiser/scoreboard (negedge).
    initial begin
        logic [31:0] exp;
        bus.vdu_ack    = 1'b0;
        bus.vdu_data   = '0;
        bus.word_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || frame_start) begin
                exp_q.delete();
                exp_addr    = base_addr;
                acks        = 0;
                bus.vdu_ack = 1'b0;
            end else if (bus.vdu_ack) begin
                bus.vdu_ack  = 1'b0;
                bus.vdu_data = mem_word(ack_addr);
                acks++;
            end else if (bus.vdu_req && !hold) begin
                checks++;
                if (bus.vdu_address !== exp_addr) begin
                    errors++;
                    $display("FAIL req_addr: got %h expected %h",
                             bus.vdu_address, exp_addr);
                end
                if (acks == 0) first_addr = bus.vdu_address;
                ack_addr = bus.vdu_address;
                exp_q.push_back(mem_word(bus.vdu_address));
                exp_addr    = exp_addr + 1'b1;
                bus.vdu_ack = 1'b1;
            end
            @(negedge clk);
            #1;
            case (rmode)
                0:       bus.word_ready = 1'b0;
                1:       bus.word_ready = 1'b1;
                2:       bus.word_ready = bus.word_valid;
                default: bus.word_ready = bus.word_valid &&
                                          ($urandom_range(0, 1) == 1);
            endcase
            #1;
            if (bus.word_valid && bus.word_ready && !reset) begin
                checks++;
                pops++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_extra: got %h expected none",
                             bus.word_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.word_data !== exp) begin
                        errors++;
                        $display("FAIL word_data: got %h expected %h",
                                 bus.word_data, exp);
                    end
                end
            end
        end
    end

    task automatic start_frame(input logic [AW-1:0] a);
        @(negedge clk);
        base_addr   = a;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (!(frame_done && exp_q.size() == 0 && !bus.word_valid)
               && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL %s_timeout: done=%b left=%0d required drained",
                     name, frame_done, exp_q.size());
        end
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (acks != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_ack_wait: acks=%0d required %0d",
                     name, acks, target);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus.vdu_req !== 1'b0 || bus.vdu_address !== '0 ||
            bus.word_valid !== 1'b0 || bus.word_data !== '0 ||
            frame_done !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: req=%b addr=%h v=%b d=%h done=%b ur=%b required 0,0,0,0,1,0",
                     name, bus.vdu_req, bus.vdu_address, bus.word_valid,
                     bus.word_data, frame_done, underrun);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.vdu_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %b required 0", bus.vdu_req);
        end
    endtask

    task automatic test_streaming();
        int p0;
        rmode = 3;
        hold  = 1'b0;
        p0    = pops;
        start_frame(18'h01000);
        wait_drained("stream");
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL stream_underrun: got %b required 0", underrun);
        end
        checks++;
        if (pops - p0 != FW || first_addr !== 18'h01000) begin
            errors++;
            $display("FAIL stream_count: pops=%0d first=%h required %0d, 01000",
                     pops - p0, first_addr, FW);
        end
    endtask

    task automatic test_throughput();
        int n = 0;
        rmode = 2;
        start_frame(AW'($urandom));
        wait_acks(1, "tput");
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 2 * (FW - 1) + 1) begin
            errors++;
            $display("FAIL throughput: cycles=%0d required %0d",
                     n, 2 * (FW - 1) + 1);
        end
        wait_drained("tput");
    endtask

    task automatic test_backpressure();
        int p0;
        rmode = 0;
        start_frame(AW'($urandom));
        repeat (60) @(negedge clk);
        checks++;
        if (acks != DEPTH || bus.vdu_req !== 1'b0 ||
            bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: acks=%0d req=%b valid=%b required %0d,0,1",
                     acks, bus.vdu_req, bus.word_valid, DEPTH);
        end
        p0 = pops;
        rmode = 1;
        @(negedge clk);
        rmode = 0;
        repeat (30) @(negedge clk);
        checks++;
        if (acks != DEPTH + 1 || bus.vdu_req !== 1'b0 ||
            pops - p0 != 1) begin
            errors++;
            $display("FAIL bp_one_more: acks=%0d req=%b pops=%0d required %0d,0,1",
                     acks, bus.vdu_req, pops - p0, DEPTH + 1);
        end
        rmode = 2;
        wait_drained("bp");
    endtask

    task automatic test_priority_stall();
        logic [AW-1:0] b;
        int bad = 0;
        b     = AW'($urandom);
        rmode = 2;
        hold  = 1'b1;
        start_frame(b);
        repeat (10) begin
            @(negedge clk);
            if (bus.vdu_req !== 1'b1 || bus.vdu_address !== b) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: bad_cycles=%0d addr=%h required 0, %h",
                     bad, bus.vdu_address, b);
        end
        rmode = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL stall_underrun: got %b required 1", underrun);
        end
        rmode = 2;
        hold  = 1'b0;
        wait_drained("stall");
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: got %b required 1", underrun);
        end
    endtask

    task automatic test_frame_end();
        rmode = 2;
        start_frame(18'h3FFF8);
        checks++;
        if (underrun !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL fe_start: ur=%b done=%b required 0,0",
                     underrun, frame_done);
        end
        wait_acks(FW, "fe");
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL fe_early_done: got %b required 0", frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || bus.vdu_req !== 1'b0) begin
            errors++;
            $display("FAIL fe_done: done=%b req=%b required 1,0",
                     frame_done, bus.vdu_req);
        end
        checks++;
        if (exp_addr !== 18'h00008) begin
            errors++;
            $display("FAIL fe_wrap: next=%h required 00008", exp_addr);
        end
        wait_drained("fe");
        rmode = 1;
        repeat (4) @(negedge clk);
        rmode = 0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL fe_idle_underrun: got %b required 0", underrun);
        end
    endtask

    task automatic test_restart();
        int p0;
        rmode = 0;
        start_frame(18'h01234);
        wait_acks(3, "rs");
        base_addr   = 18'h02000;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (bus.word_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rs_flush: valid=%b done=%b required 0,0",
                     bus.word_valid, frame_done);
        end
        p0 = pops;
        wait_acks(1, "rs2");
        checks++;
        if (first_addr !== 18'h02000) begin
            errors++;
            $display("FAIL rs_addr: got %h required 02000", first_addr);
        end
        rmode = 2;
        wait_drained("rs");
        checks++;
        if (pops - p0 != FW) begin
            errors++;
            $display("FAIL rs_count: pops=%0d required %0d", pops - p0, FW);
        end
    endtask

    task automatic test_async_reset();
        rmode = 0;
        start_frame(AW'($urandom));
        wait_acks(4, "ar");
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rmode = 2;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.word_valid !== 1'b0 || bus.vdu_req !== 1'b0 ||
            frame_done !== 1'b1) begin
            errors++;
            $display("FAIL ar_after: valid=%b req=%b done=%b required 0,0,1",
                     bus.word_valid, bus.vdu_req, frame_done);
        end
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_streaming();
        test_throughput();
        test_backpressure();
        test_priority_stall();
        test_frame_end();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
